// File: rtl/ball_split_ctrl.sv
// Purpose: on a harpoon hit, latch the parent ball and emit two child-spawn commands plus parent removal at the next frame.
// Latency: capture on the hit edge; spawn1 appears one cycle after the next startOfFrame, spawn2/parentKill one cycle later.
// Backpressure: none; hits arriving outside IDLE (including cooldown) are dropped, not queued. Optional macro: SPLIT_MIN_BOUNCE_EN.
module ball_split_ctrl #(
    parameter int CHILD_OFFSET    = 16,
    parameter int SCREEN_W        = 640,
    parameter int COOLDOWN_FRAMES = 4,
    parameter int MIN_BOUNCE      = 64
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        collision,
    input  logic [10:0] parentX,
    input  logic [10:0] parentY,
    input  logic [15:0] parentXspeed,
    input  logic [15:0] parentYspeed,
    input  logic [1:0]  parentSize,
    output logic [15:0] Xspeed,
    output logic [15:0] Yspeed,
    input  logic [15:0] Xspeed1_in,
    input  logic [15:0] Xspeed2_in,
    input  logic [15:0] Yspeed_both_in,
    output logic        spawn1,
    output logic        spawn2,
    output logic [10:0] spawnX,
    output logic [10:0] spawnY,
    output logic [15:0] spawnXspeed,
    output logic [15:0] spawnYspeed,
    output logic [1:0]  spawnSize,
    output logic        parentKill,
    output logic        scorePulse,
    output logic        busy
);

`ifdef SPLIT_MIN_BOUNCE_EN
    localparam bit MIN_BOUNCE_EN = 1'b1;
`else
    localparam bit MIN_BOUNCE_EN = 1'b0;
`endif

    localparam int CNT_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(COOLDOWN_FRAMES - 1);
    localparam logic signed [11:0] OFFSET_S = 12'(CHILD_OFFSET);
    localparam logic [11:0]        OFFSET_U = 12'(CHILD_OFFSET);
    localparam logic [11:0]        X_MAX    = 12'(SCREEN_W - 1);
    localparam logic signed [15:0] Y_FLOOR  = 16'(-MIN_BOUNCE);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        SPAWN1,
        SPAWN2,
        KILL,
        COOLDOWN
    } state_t;

    state_t           state;
    logic [10:0]      lat_x;
    logic [10:0]      lat_y;
    logic [1:0]       lat_size;
    logic [CNT_W-1:0] frame_cnt;

    logic signed [11:0] left_x_wide;
    logic [11:0]        right_x_wide;
    logic [10:0]        left_x;
    logic [10:0]        right_x;
    logic [15:0]        child_yspeed;

    // Child X positions: left clamps at 0 (signed 12-bit underflow), right clamps at the screen edge.
    always_comb begin
        left_x_wide  = $signed({1'b0, lat_x}) - OFFSET_S;
        right_x_wide = {1'b0, lat_x} + OFFSET_U;
        left_x       = left_x_wide[11] ? 11'd0 : left_x_wide[10:0];
        right_x      = (right_x_wide > X_MAX) ? X_MAX[10:0] : right_x_wide[10:0];
    end

    // Shared child Y speed; with the bounce floor enabled children always rise at least MIN_BOUNCE.
    always_comb begin
        child_yspeed = Yspeed_both_in;
        if (MIN_BOUNCE_EN && ($signed(Yspeed_both_in) > Y_FLOOR)) begin
            child_yspeed = Y_FLOOR;
        end
    end

    // Split sequencer; every output is registered on the edge that enters the cycle it belongs to.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state       <= IDLE;
            lat_x       <= '0;
            lat_y       <= '0;
            lat_size    <= '0;
            frame_cnt   <= '0;
            Xspeed      <= '0;
            Yspeed      <= '0;
            spawn1      <= 1'b0;
            spawn2      <= 1'b0;
            spawnX      <= '0;
            spawnY      <= '0;
            spawnXspeed <= '0;
            spawnYspeed <= '0;
            spawnSize   <= '0;
            parentKill  <= 1'b0;
            scorePulse  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // Pulses and spawn data default low; only the spawn cycles drive them.
            spawn1      <= 1'b0;
            spawn2      <= 1'b0;
            spawnX      <= '0;
            spawnY      <= '0;
            spawnXspeed <= '0;
            spawnYspeed <= '0;
            spawnSize   <= '0;
            parentKill  <= 1'b0;
            scorePulse  <= 1'b0;

            case (state)
                IDLE: begin
                    // A frame pulse coincident with the hit is deliberately ignored here.
                    if (collision) begin
                        lat_x    <= parentX;
                        lat_y    <= parentY;
                        lat_size <= parentSize;
                        Xspeed   <= parentXspeed;
                        Yspeed   <= parentYspeed;
                        busy     <= 1'b1;
                        state    <= WAIT_FRAME;
                    end
                end

                WAIT_FRAME: begin
                    if (startOfFrame) begin
                        if (lat_size != 2'd0) begin
                            spawn1      <= 1'b1;
                            spawnX      <= left_x;
                            spawnY      <= lat_y;
                            spawnXspeed <= Xspeed1_in;
                            spawnYspeed <= child_yspeed;
                            spawnSize   <= lat_size - 2'd1;
                            state       <= SPAWN1;
                        end else begin
                            // Smallest ball: destroyed outright, no children.
                            parentKill  <= 1'b1;
                            scorePulse  <= 1'b1;
                            state       <= KILL;
                        end
                    end
                end

                SPAWN1: begin
                    spawn2      <= 1'b1;
                    spawnX      <= right_x;
                    spawnY      <= lat_y;
                    spawnXspeed <= Xspeed2_in;
                    spawnYspeed <= child_yspeed;
                    spawnSize   <= lat_size - 2'd1;
                    parentKill  <= 1'b1;
                    scorePulse  <= 1'b1;
                    state       <= SPAWN2;
                end

                SPAWN2, KILL: begin
                    frame_cnt <= '0;
                    state     <= COOLDOWN;
                end

                COOLDOWN: begin
                    if (startOfFrame) begin
                        if (frame_cnt == CNT_LAST) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            frame_cnt <= frame_cnt + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_split_ctrl.sv
// Purpose: self-checking bench for ball_split_ctrl with a queue of expected output events.
// Latency: expectations are pushed before the frame pulse; the monitor pops them as the DUT emits pulses.
// Backpressure: none; unexpected or missing DUT events are reported as failures.
module tb_ball_split_ctrl;

`ifdef SPLIT_MIN_BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        collision = 1'b0;
    logic [10:0] parentX = '0;
    logic [10:0] parentY = '0;
    logic [15:0] parentXspeed = '0;
    logic [15:0] parentYspeed = '0;
    logic [1:0]  parentSize = '0;
    logic [15:0] Xspeed, Yspeed;
    logic [15:0] Xspeed1_in = '0;
    logic [15:0] Xspeed2_in = '0;
    logic [15:0] Yspeed_both_in = '0;
    logic        spawn1, spawn2, parentKill, scorePulse, busy;
    logic [10:0] spawnX, spawnY;
    logic [15:0] spawnXspeed, spawnYspeed;
    logic [1:0]  spawnSize;

    int tests = 0;
    int failed = 0;

    typedef struct {
        logic        s1;
        logic        s2;
        logic        kill;
        logic [10:0] x;
        logic [10:0] y;
        logic [15:0] xs;
        logic [15:0] ys;
        logic [1:0]  sz;
    } ev_t;

    ev_t exp_q[$];

    ball_split_ctrl dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .collision(collision),
        .parentX(parentX), .parentY(parentY), .parentXspeed(parentXspeed),
        .parentYspeed(parentYspeed), .parentSize(parentSize),
        .Xspeed(Xspeed), .Yspeed(Yspeed),
        .Xspeed1_in(Xspeed1_in), .Xspeed2_in(Xspeed2_in), .Yspeed_both_in(Yspeed_both_in),
        .spawn1(spawn1), .spawn2(spawn2), .spawnX(spawnX), .spawnY(spawnY),
        .spawnXspeed(spawnXspeed), .spawnYspeed(spawnYspeed), .spawnSize(spawnSize),
        .parentKill(parentKill), .scorePulse(scorePulse), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected child Y speed, hand rule: floor at -64 only when the bounce feature is built in.
    function automatic logic [15:0] exp_ys(input logic signed [15:0] v);
        return (BOUNCE && v > -16'sd64) ? -16'sd64 : v;
    endfunction

    task automatic push(input logic s1, input logic s2, input logic kill, input logic [10:0] x,
                        input logic [10:0] y, input logic [15:0] xs, input logic [15:0] ys,
                        input logic [1:0] sz);
        ev_t e;
        e.s1 = s1; e.s2 = s2; e.kill = kill; e.x = x; e.y = y; e.xs = xs; e.ys = ys; e.sz = sz;
        exp_q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, pops an expectation for every pulse cycle.
    always @(negedge clk) begin
        if (spawn1 || spawn2 || parentKill || scorePulse) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {spawn1, spawn2, parentKill, scorePulse}, 64'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("ev_spawn1", spawn1, e.s1);
                chk("ev_spawn2", spawn2, e.s2);
                chk("ev_kill", parentKill, e.kill);
                chk("ev_score", scorePulse, e.kill);
                chk("ev_x", spawnX, e.x);
                chk("ev_y", spawnY, e.y);
                chk("ev_xspeed", spawnXspeed, e.xs);
                chk("ev_yspeed", spawnYspeed, e.ys);
                chk("ev_size", spawnSize, e.sz);
            end
        end else if (resetN) begin
            chk("idle_data_zero", {spawnX, spawnY, spawnXspeed, spawnYspeed, spawnSize}, 64'd0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        step(1);
        startOfFrame = 1'b0;
    endtask

    task automatic hit(input logic [10:0] x, input logic [10:0] y, input logic [15:0] xs,
                       input logic [15:0] ys, input logic [1:0] sz, input logic with_sof);
        parentX = x; parentY = y; parentXspeed = xs; parentYspeed = ys; parentSize = sz;
        collision = 1'b1;
        startOfFrame = with_sof;
        step(1);
        collision = 1'b0;
        startOfFrame = 1'b0;
    endtask

    task automatic split_in(input logic [15:0] x1, input logic [15:0] x2, input logic [15:0] y);
        Xspeed1_in = x1; Xspeed2_in = x2; Yspeed_both_in = y;
    endtask

    // Walk through the two pulse cycles and the four cooldown frames back to IDLE.
    task automatic finish_cooldown();
        step(3);
        repeat (3) sof();
        chk("busy_before_last_sof", busy, 1'b1);
        sof();
        chk("busy_after_last_sof", busy, 1'b0);
    endtask

    initial begin
        step(3);
        chk("rst_busy", busy, 1'b0);
        chk("rst_speeds", {Xspeed, Yspeed}, 64'd0);
        chk("rst_pulses", {spawn1, spawn2, parentKill, scorePulse}, 64'd0);
        chk("rst_spawn_data", {spawnX, spawnY, spawnXspeed, spawnYspeed, spawnSize}, 64'd0);
        resetN = 1'b1;
        step(2);

        // Basic split of a size-2 ball.
        split_in(16'd50, -16'sd50, -16'sd30);
        hit(11'd200, 11'd100, 16'd50, 16'd30, 2'd2, 1'b0);
        chk("cap_busy", busy, 1'b1);
        chk("cap_xspeed", Xspeed, 16'd50);
        chk("cap_yspeed", Yspeed, 16'd30);
        push(1'b1, 1'b0, 1'b0, 11'd184, 11'd100, 16'd50, exp_ys(-16'sd30), 2'd1);
        push(1'b0, 1'b1, 1'b1, 11'd216, 11'd100, -16'sd50, exp_ys(-16'sd30), 2'd1);
        sof();
        step(3);
        hit(11'd400, 11'd50, 16'd7, 16'd8, 2'd3, 1'b0);
        chk("cooldown_hit_ignored", Xspeed, 16'd50);
        repeat (3) sof();
        chk("busy_before_last_sof", busy, 1'b1);
        sof();
        chk("busy_after_last_sof", busy, 1'b0);

        // Smallest ball: kill only; second hit in WAIT_FRAME dropped.
        hit(11'd300, 11'd40, 16'd11, 16'd12, 2'd0, 1'b0);
        hit(11'd500, 11'd60, 16'd99, 16'd98, 2'd2, 1'b0);
        chk("waitframe_hit_ignored", Xspeed, 16'd11);
        push(1'b0, 1'b0, 1'b1, 11'd0, 11'd0, 16'd0, 16'd0, 2'd0);
        sof();
        finish_cooldown();

        // Left clamp; coincident frame pulse on the hit is not used.
        split_in(-16'sd20, 16'sd20, -16'sd40);
        hit(11'd5, 11'd200, 16'd3, 16'd4, 2'd1, 1'b1);
        step(3);
        chk("same_cycle_sof_wait", busy, 1'b1);
        push(1'b1, 1'b0, 1'b0, 11'd0, 11'd200, -16'sd20, exp_ys(-16'sd40), 2'd0);
        push(1'b0, 1'b1, 1'b1, 11'd21, 11'd200, 16'sd20, exp_ys(-16'sd40), 2'd0);
        sof();
        finish_cooldown();

        // Right clamp, shallow child speed (floored only with the feature).
        split_in(16'sd5, -16'sd5, -16'sd10);
        hit(11'd630, 11'd300, 16'd1, 16'd2, 2'd3, 1'b0);
        push(1'b1, 1'b0, 1'b0, 11'd614, 11'd300, 16'sd5, exp_ys(-16'sd10), 2'd2);
        push(1'b0, 1'b1, 1'b1, 11'd639, 11'd300, -16'sd5, exp_ys(-16'sd10), 2'd2);
        sof();
        finish_cooldown();

        // Steep child speed passes through unchanged.
        split_in(16'sd9, -16'sd9, -16'sd100);
        hit(11'd320, 11'd10, 16'd9, 16'd9, 2'd1, 1'b0);
        push(1'b1, 1'b0, 1'b0, 11'd304, 11'd10, 16'sd9, -16'sd100, 2'd0);
        push(1'b0, 1'b1, 1'b1, 11'd336, 11'd10, -16'sd9, -16'sd100, 2'd0);
        sof();
        finish_cooldown();

        // Reset during WAIT_FRAME drops the pending split.
        hit(11'd250, 11'd250, 16'd5, 16'd6, 2'd2, 1'b0);
        resetN = 1'b0;
        step(1);
        resetN = 1'b1;
        sof();
        step(3);
        chk("rst_wait_busy", busy, 1'b0);
        chk("rst_wait_speeds", {Xspeed, Yspeed}, 64'd0);
        chk("rst_wait_pulses", {spawn1, spawn2, parentKill, scorePulse}, 64'd0);

        // Hit accepted again after reset.
        hit(11'd100, 11'd100, 16'd33, 16'd44, 2'd0, 1'b0);
        chk("post_rst_accept", busy, 1'b1);
        chk("post_rst_xspeed", Xspeed, 16'd33);
        push(1'b0, 1'b0, 1'b1, 11'd0, 11'd0, 16'd0, 16'd0, 2'd0);
        sof();
        finish_cooldown();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1);
        chk("queue_drained", exp_q.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
